// File: rtl/shiftram_var.sv
// shiftram_var: runtime-programmable delay line built on a circular block RAM
// Ports: clk, rst_n (sync, active low); shift/d push one word per cycle;
//   len_load/len_in request a new delay length in 1..DEPTH (rejects pulse len_err);
//   q is the delayed word (0 until q_valid); len is the active length; fill counts
//   shifts since reset/load, saturating at len; busy is high while a flush runs.
// Optional macro SHIFTRAM_FLUSH_EN adds the flush input and a DEPTH-cycle zero-fill.
module shiftram_var #(
  parameter int DWIDTH    = 16,
  parameter int DEPTH     = 256,
  parameter int RESET_LEN = DEPTH,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift,
  input  logic [DWIDTH-1:0] d,
  input  logic              len_load,
  input  logic [AW:0]       len_in,
`ifdef SHIFTRAM_FLUSH_EN
  input  logic              flush,
`endif
  output logic [DWIDTH-1:0] q,
  output logic              q_valid,
  output logic [AW:0]       len,
  output logic [AW:0]       fill,
  output logic              len_err,
  output logic              busy
);
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  localparam logic [AW:0] L1   = (AW+1)'(1);
  localparam logic [AW:0] LMAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LRST = (AW+1)'(RESET_LEN);
`ifdef SHIFTRAM_FLUSH_EN
  localparam logic [AW-1:0] WLAST = AW'(DEPTH-1);
`endif
  state_t state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, raddr;
  logic [AW:0] len_q, len_d, fill_q, fill_d;
  logic err_q, err_d, ok, sh, vld, clr, we;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdat_q, wdata;
  always_comb begin
`ifdef SHIFTRAM_FLUSH_EN
    sh = shift && state_q != FLUSH && !flush;
`else
    sh = shift;
`endif
    ok = len_load && len_in != '0 && len_in <= LMAX;
    len_d = ok ? len_in : len_q;
    err_d = len_load && !ok;
    fill_d = ok ? (sh ? L1 : '0) : (sh && fill_q < len_q) ? fill_q + 1'b1 : fill_q;
    vld = fill_d == len_d;
    state_d = vld ? RUN : FILL;
    wp_d = sh ? wp_q + 1'b1 : wp_q;
    we = sh;
    wdata = d;
    clr = 1'b0;
    // wp - (len-1) mod DEPTH; len=DEPTH truncates to 0 so this stays correct
    raddr = wp_q + 1'b1 - len_d[AW-1:0];
`ifdef SHIFTRAM_FLUSH_EN
    if (state_q == FLUSH) begin
      len_d = len_q;
      err_d = 1'b0;
      we = 1'b1;
      wdata = '0;
      clr = 1'b1;
      wp_d = wp_q + 1'b1;
      fill_d = wp_q == WLAST ? len_q : '0;
      state_d = wp_q == WLAST ? RUN : FLUSH;
    end else if (flush) begin
      fill_d = '0;
      wp_d = '0;
      clr = 1'b1;
      state_d = FLUSH;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      wp_q <= '0;
      len_q <= LRST;
      fill_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      len_q <= len_d;
      fill_q <= fill_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) if (we) mem[wp_q] <= wdata;
  // len==1 bypasses the RAM: the word written this cycle is the one to emit
  always_ff @(posedge clk) begin
    if (!rst_n || clr) rdat_q <= '0;
    else if (sh) rdat_q <= len_d == L1 ? d : mem[raddr];
  end
  assign q_valid = state_q == RUN;
  assign q = q_valid ? rdat_q : '0;
  assign len = len_q;
  assign fill = fill_q;
  assign len_err = err_q;
`ifdef SHIFTRAM_FLUSH_EN
  assign busy = state_q == FLUSH;
`else
  assign busy = 1'b0;
`endif
endmodule
